// File: rtl/sbox_share_ctrl.sv
// ---------------------------------------------------------------------------
// sbox_share_ctrl
//
// Purpose:
//   Shares one AES SubBytes S-box between two requesters: the round datapath
//   (16-byte state) and key expansion (4-byte SubWord). One job is accepted
//   at a time. Its bytes go through the S-box one per cycle, and each result
//   is assembled into a result register owned by that port. Completion is
//   signalled with a one-cycle done pulse.
//
// Configuration:
//   PRIO_KEY      parameter, 1 = key port wins a same-cycle tie,
//                 0 = round-robin (the port not granted last wins).
//   SBOX_PIPE_EN  define to register the S-box output (adds a DRAIN state,
//                 +1 cycle latency per job).
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_st_valid/o_st_ready state job handshake, i_st_data byte 0 = [127:120]
//   o_st_done/o_st_result one-cycle done pulse and substituted state
//   i_kw_valid/o_kw_ready key-word job handshake, i_kw_data byte 0 = [31:24]
//   o_kw_done/o_kw_result one-cycle done pulse and SubWord result
//   o_busy                a job currently owns the S-box
// ---------------------------------------------------------------------------
module sbox_share_ctrl #(
  parameter int PRIO_KEY = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_st_valid,
  output logic         o_st_ready,
  input  logic [127:0] i_st_data,
  output logic         o_st_done,
  output logic [127:0] o_st_result,
  input  logic         i_kw_valid,
  output logic         o_kw_ready,
  input  logic [31:0]  i_kw_data,
  output logic         o_kw_done,
  output logic [31:0]  o_kw_result,
  output logic         o_busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN_ST = 2'd1;
  localparam logic [1:0] RUN_KW = 2'd2;
`ifdef SBOX_PIPE_EN
  localparam logic [1:0] DRAIN  = 2'd3;
`endif

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box: multiplicative inverse (a^254, which maps 0 to 0) then the affine map.
  function automatic logic [7:0] sbox_byte(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  logic [1:0]   r_state;
  logic [3:0]   r_idx;
  logic [127:0] r_buf;
  logic         r_rdy;
  logic         r_last_kw;
  logic         r_busy;
  logic         r_st_done;
  logic         r_kw_done;
  logic [127:0] r_st_result;
  logic [31:0]  r_kw_result;

  logic         w_key_wins;
  logic         w_idle;
  logic         w_st_acc;
  logic         w_kw_acc;
  logic         w_last;
  logic [6:0]   w_rd_lsb;
  logic [7:0]   w_sbox_in;
  logic [7:0]   w_sbox_out;

  // r_last_kw is 0 after reset, so round-robin starts as if the state port
  // had been granted last.
  assign w_key_wins = (PRIO_KEY != 0) ? 1'b1 : ~r_last_kw;
  assign w_idle     = (r_state == IDLE);
  assign o_st_ready = r_rdy & w_idle & ~(i_kw_valid & w_key_wins);
  assign o_kw_ready = r_rdy & w_idle & ~(i_st_valid & ~w_key_wins);
  assign w_st_acc   = i_st_valid & o_st_ready;
  assign w_kw_acc   = i_kw_valid & o_kw_ready;

  assign w_last = ((r_state == RUN_ST) && (r_idx == 4'd15)) ||
                  ((r_state == RUN_KW) && (r_idx == 4'd3));

  // A key word is parked in the top of the buffer, so byte idx sits at bit
  // offset 8*(15-idx) for both job types; 15-idx is ~idx for a 4-bit idx.
  assign w_rd_lsb   = {~r_idx, 3'b000};
  assign w_sbox_in  = r_buf[w_rd_lsb +: 8];
  assign w_sbox_out = sbox_byte(w_sbox_in);

  assign o_busy      = r_busy;
  assign o_st_done   = r_st_done;
  assign o_kw_done   = r_kw_done;
  assign o_st_result = r_st_result;
  assign o_kw_result = r_kw_result;

  // Control FSM: accepts a job in IDLE, walks idx through its bytes, and
  // raises the matching done pulse in the first IDLE cycle afterwards.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_idx     <= 4'd0;
      r_buf     <= '0;
      r_rdy     <= 1'b0;
      r_last_kw <= 1'b0;
      r_busy    <= 1'b0;
      r_st_done <= 1'b0;
      r_kw_done <= 1'b0;
    end else begin
      r_rdy     <= 1'b1;
      r_st_done <= 1'b0;
      r_kw_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_st_acc) begin
            r_buf     <= i_st_data;
            r_idx     <= 4'd0;
            r_state   <= RUN_ST;
            r_last_kw <= 1'b0;
            r_busy    <= 1'b1;
          end else if (w_kw_acc) begin
            r_buf     <= {i_kw_data, 96'd0};
            r_idx     <= 4'd0;
            r_state   <= RUN_KW;
            r_last_kw <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        RUN_ST, RUN_KW: begin
          if (w_last) begin
`ifdef SBOX_PIPE_EN
            r_state   <= DRAIN;
`else
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_st_done <= (r_state == RUN_ST);
            r_kw_done <= (r_state == RUN_KW);
`endif
          end else begin
            r_idx <= r_idx + 4'd1;
          end
        end
`ifdef SBOX_PIPE_EN
        DRAIN: begin
          r_state   <= IDLE;
          r_busy    <= 1'b0;
          r_st_done <= ~r_last_kw;
          r_kw_done <= r_last_kw;
        end
`endif
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SBOX_PIPE_EN
  logic [7:0] r_pipe;
  logic [3:0] r_pipe_idx;
  logic       r_pipe_vld;

  // The S-box output is registered along with its byte index; the write
  // lands one edge later. During DRAIN r_last_kw still names the job owner.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pipe      <= 8'h00;
      r_pipe_idx  <= 4'd0;
      r_pipe_vld  <= 1'b0;
      r_st_result <= '0;
      r_kw_result <= '0;
    end else begin
      r_pipe     <= w_sbox_out;
      r_pipe_idx <= r_idx;
      r_pipe_vld <= (r_state == RUN_ST) || (r_state == RUN_KW);
      if (r_pipe_vld) begin
        if (r_last_kw) r_kw_result[{~r_pipe_idx[1:0], 3'b000} +: 8] <= r_pipe;
        else           r_st_result[{~r_pipe_idx, 3'b000} +: 8]      <= r_pipe;
      end
    end
  end
`else
  // The S-box output is written straight into the running port's result byte.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_st_result <= '0;
      r_kw_result <= '0;
    end else begin
      if (r_state == RUN_ST) r_st_result[w_rd_lsb +: 8] <= w_sbox_out;
      if (r_state == RUN_KW) r_kw_result[{~r_idx[1:0], 3'b000} +: 8] <= w_sbox_out;
    end
  end
`endif

endmodule

// File: tb/tb_sbox_share_ctrl.sv
// Self-checking bench for sbox_share_ctrl. One instance uses key priority and
// a second uses round-robin; every expectation comes from an S-box lookup
// table and the arbitration and latency rules of the block.
module tb_sbox_share_ctrl;

`ifdef SBOX_PIPE_EN
  localparam int PIPE = 1;
`else
  localparam int PIPE = 0;
`endif
  localparam int LAT_ST = 17 + PIPE;
  localparam int LAT_KW = 5 + PIPE;

  localparam logic [0:255][7:0] SBOX_T = {
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  logic clk = 1'b0;
  logic rstN;
  always #5 clk = ~clk;

  logic         stValid, stReady, stDone, kwValid, kwReady, kwDone, busy;
  logic [127:0] stData, stResult;
  logic [31:0]  kwData, kwResult;

  logic         rrStValid, rrStReady, rrStDone, rrKwValid, rrKwReady, rrKwDone, rrBusy;
  logic [127:0] rrStData, rrStResult;
  logic [31:0]  rrKwData, rrKwResult;

  sbox_share_ctrl #(.PRIO_KEY(1)) dutK (
    .i_clk(clk), .i_rst_n(rstN),
    .i_st_valid(stValid), .o_st_ready(stReady), .i_st_data(stData),
    .o_st_done(stDone), .o_st_result(stResult),
    .i_kw_valid(kwValid), .o_kw_ready(kwReady), .i_kw_data(kwData),
    .o_kw_done(kwDone), .o_kw_result(kwResult), .o_busy(busy)
  );

  sbox_share_ctrl #(.PRIO_KEY(0)) dutR (
    .i_clk(clk), .i_rst_n(rstN),
    .i_st_valid(rrStValid), .o_st_ready(rrStReady), .i_st_data(rrStData),
    .o_st_done(rrStDone), .o_st_result(rrStResult),
    .i_kw_valid(rrKwValid), .o_kw_ready(rrKwReady), .i_kw_data(rrKwData),
    .o_kw_done(rrKwDone), .o_kw_result(rrKwResult), .o_busy(rrBusy)
  );

  int tests = 0;
  int fails = 0;

  function automatic logic [127:0] subState(input logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = SBOX_T[d[127-8*i -: 8]];
    return r;
  endfunction

  function automatic logic [31:0] subWord(input logic [31:0] d);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[31-8*i -: 8] = SBOX_T[d[31-8*i -: 8]];
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic sv, input logic [127:0] sd, input logic kv, input logic [31:0] kd);
    stValid = sv;
    stData  = sd;
    kwValid = kv;
    kwData  = kd;
  endtask

  // Runs one uncontended job on the key-priority instance and checks
  // handshake, latency, busy window, result, and the other port's result.
  task automatic jobK(input bit isKw, input logic [127:0] data, input string tag);
    logic [127:0] stBefore;
    logic [31:0]  kwBefore;
    int cyc, busyCnt;
    bit seen;
    stBefore = stResult;
    kwBefore = kwResult;
    @(negedge clk);
    if (isKw) applyStimulus(1'b0, '0, 1'b1, data[31:0]);
    else      applyStimulus(1'b1, data, 1'b0, '0);
    #1;
    checkOutput({tag, "_ready"}, isKw ? kwReady : stReady, 1'b1);
    @(posedge clk);
    cyc = 0; busyCnt = 0; seen = 0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      applyStimulus(1'b0, '0, 1'b0, '0);
      cyc++;
      if (isKw ? kwDone : stDone) seen = 1;
      else if (busy) busyCnt++;
    end
    checkOutput({tag, "_latency"}, cyc, isKw ? LAT_KW : LAT_ST);
    checkOutput({tag, "_busyCycles"}, busyCnt, (isKw ? LAT_KW : LAT_ST) - 1);
    checkOutput({tag, "_busyInDone"}, busy, 1'b0);
    if (isKw) begin
      checkOutput({tag, "_kwResult"}, kwResult, subWord(data[31:0]));
      checkOutput({tag, "_stUntouched"}, stResult, stBefore);
    end else begin
      checkOutput({tag, "_stResult"}, stResult, subState(data));
      checkOutput({tag, "_kwUntouched"}, kwResult, kwBefore);
    end
    @(negedge clk);
    checkOutput({tag, "_donePulse"}, isKw ? kwDone : stDone, 1'b0);
  endtask

  logic [127:0] sd, expSt;
  logic [31:0]  kd, expKw;
  int cyc, doneCnt, grants, dones;
  bit seen, modelLastKw, expGrantKw, updSt, updKw;

  initial begin
    rstN = 1'b0;
    rrStValid = 1'b0; rrKwValid = 1'b0; rrStData = '0; rrKwData = '0;
    applyStimulus(1'b1, 128'h0123456789abcdef0123456789abcdef, 1'b1, 32'h89abcdef);

    // Reset state, with both valids held high.
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rstStReady", stReady, 1'b0);
    checkOutput("rstKwReady", kwReady, 1'b0);
    checkOutput("rstBusy", busy, 1'b0);
    checkOutput("rstStDone", stDone, 1'b0);
    checkOutput("rstKwDone", kwDone, 1'b0);
    checkOutput("rstStResult", stResult, '0);
    checkOutput("rstKwResult", kwResult, '0);

    // Readies stay low until the first edge after release.
    @(negedge clk);
    rstN = 1'b1;
    #1;
    checkOutput("relStReady", stReady, 1'b0);
    checkOutput("relKwReady", kwReady, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, '0);

    // Known-answer jobs.
    jobK(1'b0, 128'h00112233445566778899aabbccddeeff, "plan1");
    checkOutput("plan1Vector", stResult, 128'h638293c31bfc33f5c4eeacea4bc12816);
    jobK(1'b1, {96'd0, 32'hcf4f3c09}, "plan2");
    checkOutput("plan2Vector", kwResult, 32'h8a84eb01);

    // Randomized uncontended jobs.
    for (int j = 0; j < 6; j++)
      jobK(1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom}, $sformatf("rand%0d", j));

    // Same-cycle tie on the key-priority instance: key first, state back-to-back.
    sd = {$urandom, $urandom, $urandom, $urandom};
    kd = $urandom;
    @(negedge clk);
    applyStimulus(1'b1, sd, 1'b1, kd);
    #1;
    checkOutput("tieKwReady", kwReady, 1'b1);
    checkOutput("tieStReady", stReady, 1'b0);
    @(posedge clk);
    cyc = 0; seen = 0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      if (cyc == 0) applyStimulus(1'b1, sd, 1'b0, '0);
      cyc++;
      if (kwDone) seen = 1;
    end
    checkOutput("tieKwLatency", cyc, LAT_KW);
    checkOutput("tieKwResult", kwResult, subWord(kd));
    #1;
    checkOutput("tieStReadyInDone", stReady, 1'b1);
    @(posedge clk);
    cyc = 0; seen = 0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      if (cyc == 0) applyStimulus(1'b0, '0, 1'b0, '0);
      cyc++;
      if (stDone) seen = 1;
    end
    checkOutput("tieStLatency", cyc, LAT_ST);
    checkOutput("tieStResult", stResult, subState(sd));

    // Reset pulsed in the middle of a state job.
    sd = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    applyStimulus(1'b1, sd, 1'b0, '0);
    @(posedge clk);
    repeat (8) begin
      @(negedge clk);
      applyStimulus(1'b0, '0, 1'b0, '0);
    end
    rstN = 1'b0;
    applyStimulus(1'b1, sd, 1'b0, '0);
    #1;
    checkOutput("abortStResult", stResult, '0);
    checkOutput("abortStReady", stReady, 1'b0);
    checkOutput("abortBusy", busy, 1'b0);
    checkOutput("abortStDone", stDone, 1'b0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    #1;
    checkOutput("abortRelReady", stReady, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, '0);
    doneCnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (stDone || busy) doneCnt++;
    end
    checkOutput("abortNoResume", doneCnt, 0);
    checkOutput("abortResultHeld", stResult, '0);
    jobK(1'b0, {8'h53, $urandom, $urandom, $urandom, 24'h000000}, "fresh");
    checkOutput("fresh53", stResult[127:120], 8'hed);

    // Round-robin instance with both valids held: grants alternate from key.
    @(negedge clk);
    rrStData = {$urandom, $urandom, $urandom, $urandom};
    rrKwData = $urandom;
    rrStValid = 1'b1;
    rrKwValid = 1'b1;
    modelLastKw = 1'b0;
    grants = 0; dones = 0; cyc = 0; updSt = 0; updKw = 0;
    while (dones < 4 && cyc < 300) begin
      #1;
      if (rrStDone) begin
        checkOutput("rrStResult", rrStResult, expSt);
        dones++;
      end
      if (rrKwDone) begin
        checkOutput("rrKwResult", rrKwResult, expKw);
        dones++;
      end
      if (grants < 4 && (rrStReady || rrKwReady)) begin
        expGrantKw = !modelLastKw;
        checkOutput($sformatf("rrGrant%0dKw", grants), rrKwReady, expGrantKw);
        checkOutput($sformatf("rrGrant%0dSt", grants), rrStReady, !expGrantKw);
        if (rrKwReady) begin
          expKw = subWord(rrKwData);
          updKw = 1;
        end else begin
          expSt = subState(rrStData);
          updSt = 1;
        end
        modelLastKw = expGrantKw;
        grants++;
      end
      @(negedge clk);
      cyc++;
      if (updKw) begin rrKwData = $urandom; updKw = 0; end
      if (updSt) begin rrStData = {$urandom, $urandom, $urandom, $urandom}; updSt = 0; end
      if (grants == 4) begin rrStValid = 1'b0; rrKwValid = 1'b0; end
    end
    checkOutput("rrGrantCount", grants, 4);
    checkOutput("rrDoneCount", dones, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
